// File: rtl/wrr_arb_pkg.sv
// Shared helpers for the weighted round-robin arbiter: weight mapping and index wrap.
package wrr_arb_pkg;

   // A programmed weight of zero still earns one grant per turn.
   function automatic int eff_weight(input int w);
      return (w == 0) ? 1 : w;
   endfunction

   function automatic int next_idx(input int idx, input int n);
      return (idx >= n - 1) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/wrr_arb_lock_if.sv
// Requester/downstream bundle of the weighted round-robin arbiter.
interface wrr_arb_lock_if #(
   parameter int NumIn     = 8,
   parameter int DataWidth = 32
);
   localparam int IdxWidth = (NumIn > 1) ? $clog2(NumIn) : 1;

   logic [NumIn-1:0]           req_i;
   logic [NumIn*DataWidth-1:0] data_i;
   logic [NumIn-1:0]           gnt_o;
   logic                       req_o;
   logic                       gnt_i;
   logic [DataWidth-1:0]       data_o;
   logic [IdxWidth-1:0]        idx_o;

   modport master (
      output req_i, data_i, gnt_i,
      input  gnt_o, req_o, data_o, idx_o
   );

   modport slave (
      input  req_i, data_i, gnt_i,
      output gnt_o, req_o, data_o, idx_o
   );
endinterface

// File: rtl/wrr_arb_prio_sel.sv
// Find-first-set over the request vector, starting at ptr and wrapping past NumIn-1.
module wrr_arb_prio_sel
   import wrr_arb_pkg::*;
#(
   parameter int NumIn    = 8,
   parameter int IdxWidth = 3
) (
   input  logic [NumIn-1:0]    req,
   input  logic [IdxWidth-1:0] ptr,
   output logic [IdxWidth-1:0] idx,
   output logic                valid
);
   logic [IdxWidth-1:0] scan_pos;

   always_comb begin
      idx      = '0;
      valid    = 1'b0;
      scan_pos = ptr;
      for (int i = 0; i < NumIn; i++) begin
         if (!valid && req[scan_pos]) begin
            idx   = scan_pos;
            valid = 1'b1;
         end
         scan_pos = IdxWidth'(next_idx(int'(scan_pos), NumIn));
      end
   end
endmodule

// File: rtl/wrr_arb_lock.sv
// Weighted round-robin arbiter with burst credits, lock-in while downstream stalls,
// and optional starvation flags enabled by defining WRR_ARB_STARVE_EN.
module wrr_arb_lock
   import wrr_arb_pkg::*;
#(
   parameter int NumIn       = 8,
   parameter int DataWidth   = 32,
   parameter int WeightWidth = 4,
   parameter int LockIn      = 1,
   parameter int MaxWait     = 64
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         flush_i,
   input  logic [NumIn*WeightWidth-1:0] weight_i,
   wrr_arb_lock_if.slave                bus,
   output logic [NumIn-1:0]             starve_o
);
   localparam int IdxWidth = (NumIn > 1) ? $clog2(NumIn) : 1;

   typedef struct packed {
      logic [IdxWidth-1:0]    ptr;
      logic [WeightWidth-1:0] cnt;
      logic                   lock;
      logic [IdxWidth-1:0]    lidx;
   } arb_state_t;

   if (NumIn < 1 || MaxWait < 1) begin : g_param_check
      $error("wrr_arb_lock: NumIn and MaxWait must be at least 1");
   end

   arb_state_t             state_reg, state_next;
   logic [WeightWidth-1:0] weight_arr [NumIn];
   logic [DataWidth-1:0]   data_arr [NumIn];
   logic [NumIn-1:0]       gnt_vec;
   logic [IdxWidth-1:0]    scan_idx, win_idx;
   logic                   scan_valid, xfer;
   logic [WeightWidth-1:0] rem;

   genvar gi;
   generate
      for (gi = 0; gi < NumIn; gi++) begin : g_lane
         assign weight_arr[gi] = weight_i[gi*WeightWidth +: WeightWidth];
         assign data_arr[gi]   = bus.data_i[gi*DataWidth +: DataWidth];
         assign gnt_vec[gi]    = scan_valid & bus.gnt_i & (win_idx == IdxWidth'(gi));
      end
   endgenerate

   wrr_arb_prio_sel #(
      .NumIn    (NumIn),
      .IdxWidth (IdxWidth)
   ) u_prio_sel (
      .req   (bus.req_i),
      .ptr   (state_reg.ptr),
      .idx   (scan_idx),
      .valid (scan_valid)
   );

   assign win_idx = state_reg.lock ? state_reg.lidx : scan_idx;
   assign xfer    = scan_valid & bus.gnt_i;

   // Leftover credits only count when the burst owner wins again; anyone else starts fresh.
   assign rem = (win_idx == state_reg.ptr && state_reg.cnt != '0)
              ? state_reg.cnt
              : WeightWidth'(eff_weight(int'(weight_arr[win_idx])));

   assign bus.req_o  = scan_valid;
   assign bus.idx_o  = scan_valid ? win_idx : '0;
   assign bus.data_o = scan_valid ? data_arr[win_idx] : '0;
   assign bus.gnt_o  = gnt_vec;

   always_comb begin
      state_next = state_reg;
      if (xfer) begin
         if (rem > WeightWidth'(1)) begin
            state_next.ptr = win_idx;
            state_next.cnt = rem - WeightWidth'(1);
         end else begin
            state_next.ptr = IdxWidth'(next_idx(int'(win_idx), NumIn));
            state_next.cnt = '0;
         end
         state_next.lock = 1'b0;
      end else if (LockIn != 0 && scan_valid && !state_reg.lock) begin
         state_next.lock = 1'b1;
         state_next.lidx = win_idx;
      end
      if (flush_i) begin
         state_next = '0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_reg <= '0;
      end else begin
         state_reg <= state_next;
      end
   end

   lock_holds_req: assert property (@(posedge clk_i) disable iff (rst_i || flush_i)
      state_reg.lock |-> bus.req_i[state_reg.lidx]);

`ifdef WRR_ARB_STARVE_EN
   localparam int WaitWidth = $clog2(MaxWait + 1);

   generate
      for (gi = 0; gi < NumIn; gi++) begin : g_starve
         logic [WaitWidth-1:0] wait_reg;

         always_ff @(posedge clk_i) begin
            if (rst_i || flush_i || !bus.req_i[gi] || gnt_vec[gi]) begin
               wait_reg <= '0;
            end else if (wait_reg != WaitWidth'(MaxWait)) begin
               wait_reg <= wait_reg + WaitWidth'(1);
            end
         end

         assign starve_o[gi] = (wait_reg == WaitWidth'(MaxWait));
      end
   endgenerate
`else
   assign starve_o = '0;
`endif

endmodule
